// File: rtl/serial_deserializer_if.sv
// Handshake and serial-link bundle between the bitstream source, the deserializer and its consumer.
interface serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             l_r;
    logic             s;
    logic             s_valid;
    logic             q_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output start, l_r, s, s_valid, q_ready, clr_ovr,
        input  q, q_valid, busy, frame_err, overrun
    );

    modport slave (
        input  start, l_r, s, s_valid, q_ready, clr_ovr,
        output q, q_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// Rebuilds WIDTH-bit words from a strobed serial bitstream, MSB- or LSB-first per frame.
//   state    | meaning
//   ST_IDLE  | waiting for start; s_valid ignored
//   ST_SHIFT | frame in progress, collecting bits
module serial_deserializer #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_deserializer_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    logic [0:0]       r_state;
    logic             r_dir;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_dir;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_shift;
    logic             w_done;
    logic             w_slot_free;

    // A start cycle shifts from a cleared register using the new direction.
    always_comb begin
        w_dir       = bus.start ? bus.l_r : r_dir;
        w_base      = bus.start ? '0 : r_sr;
        w_shift     = w_dir ? {w_base[WIDTH-2:0], bus.s} : {bus.s, w_base[WIDTH-1:1]};
        w_done      = (r_state == ST_SHIFT) && !bus.start && bus.s_valid && (r_cnt == CNT_LAST);
        w_slot_free = !r_q_valid || bus.q_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dir       <= 1'b0;
            r_cnt       <= 6'd0;
            r_sr        <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= bus.start && (r_state == ST_SHIFT);

            if (bus.start) begin
                r_state <= ST_SHIFT;
                r_dir   <= bus.l_r;
                r_sr    <= bus.s_valid ? w_shift : '0;
                r_cnt   <= bus.s_valid ? 6'd1 : 6'd0;
            end else if ((r_state == ST_SHIFT) && bus.s_valid) begin
                r_sr <= w_shift;
                if (w_done) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 6'd0;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end

            if (w_done && w_slot_free) begin
                r_q       <= w_shift;
                r_q_valid <= 1'b1;
            end else if (r_q_valid && bus.q_ready) begin
                r_q_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (w_done && !w_slot_free) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.q         = r_q;
    assign bus.q_valid   = r_q_valid;
    assign bus.busy      = (r_state == ST_SHIFT);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_serial_deserializer.sv
// Table vectors, directed corner sequences and random traffic against a bit-list reference model.
module tb_serial_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_deserializer_if #(.WIDTH(W)) bus ();
    serial_deserializer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // reference model: bits collected as a list, word built arithmetically on completion
    bit         m_in_frame;
    bit         m_dir;
    bit         m_bits[$];
    logic [W-1:0] m_q;
    bit         m_qv, m_ferr, m_ovr;

    typedef struct {
        logic st, lr, sb, sv, qr, clr;
        logic [W-1:0] q;
        logic qv, busy, ferr, ovr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic lr, logic sb, logic sv, logic qr, logic clr,
                                logic [W-1:0] q, logic qv, logic busy, logic ferr, logic ovr);
        vec_t v;
        v.st = st; v.lr = lr; v.sb = sb; v.sv = sv; v.qr = qr; v.clr = clr;
        v.q = q; v.qv = qv; v.busy = busy; v.ferr = ferr; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_dir = 0; m_bits.delete();
        m_q = '0; m_qv = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit st, lr, sb, sv, qr, clr);
        bit done = 0;
        bit drop = 0;
        logic [W-1:0] word = '0;
        m_ferr = st && m_in_frame;
        if (st) begin
            m_in_frame = 1; m_dir = lr; m_bits.delete();
            if (sv) m_bits.push_back(sb);
        end else if (m_in_frame && sv) begin
            m_bits.push_back(sb);
            if (m_bits.size() == W) begin
                done = 1; m_in_frame = 0;
                for (int i = 0; i < W; i++)
                    if (m_bits[i]) word = word | (W'(1) << (m_dir ? (W - 1 - i) : i));
            end
        end
        if (done) begin
            if (!m_qv || qr) begin m_q = word; m_qv = 1; end
            else drop = 1;
        end else if (m_qv && qr) begin
            m_qv = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    // called just after a negedge; returns just after the next negedge
    task automatic step(input logic st, lr, sb, sv, qr, clr);
        bus.start = st; bus.l_r = lr; bus.s = sb; bus.s_valid = sv;
        bus.q_ready = qr; bus.clr_ovr = clr;
        @(posedge clk);
        model_edge(st, lr, sb, sv, qr, clr);
        #1;
        chk("model_q", 32'(bus.q), 32'(m_q));
        chk("model_q_valid", 32'(bus.q_valid), 32'(m_qv));
        chk("model_busy", 32'(bus.busy), 32'(m_in_frame));
        chk("model_frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("model_overrun", 32'(bus.overrun), 32'(m_ovr));
        @(negedge clk);
    endtask

    task automatic idle(input logic qr);
        step(0, 0, 0, 0, qr, 0);
    endtask

    // bits[W-1] is sent first
    task automatic send_frame(input logic dir, input logic [W-1:0] bits, input int gaps, input logic qr);
        step(1, dir, 0, 0, qr, 0);
        for (int i = W - 1; i >= 0; i--) begin
            step(0, 0, bits[i], 1, qr, 0);
            if (i > 0) for (int g = 0; g < gaps; g++) idle(qr);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"}, 32'(bus.q), 0);
        chk({tag, "_q_valid"}, 32'(bus.q_valid), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_frame_err"}, 32'(bus.frame_err), 0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 0);
    endtask

    initial begin
        bus.start = 0; bus.l_r = 0; bus.s = 0; bus.s_valid = 0;
        bus.q_ready = 0; bus.clr_ovr = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1;

        // MSB-first 1011, LSB-first 1011 -> 1101, start-with-bit MSB-first 0110
        tbl.push_back(mk(1,1,0,0,1,0, 4'h0,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'h0,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 4'h0,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'h0,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hB,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 4'hB,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0, 4'hB,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hB,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 4'hB,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hB,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hD,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 4'hD,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1,0, 4'hD,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hD,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 4'hD,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 4'h6,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 4'h6,0,0,0,0));
        foreach (tbl[k]) begin
            step(tbl[k].st, tbl[k].lr, tbl[k].sb, tbl[k].sv, tbl[k].qr, tbl[k].clr);
            chk($sformatf("tbl%0d_q", k), 32'(bus.q), 32'(tbl[k].q));
            chk($sformatf("tbl%0d_q_valid", k), 32'(bus.q_valid), 32'(tbl[k].qv));
            chk($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
            chk($sformatf("tbl%0d_frame_err", k), 32'(bus.frame_err), 32'(tbl[k].ferr));
            chk($sformatf("tbl%0d_overrun", k), 32'(bus.overrun), 32'(tbl[k].ovr));
        end

        // gaps between bits
        send_frame(1, 4'b1100, 3, 1);
        chk("gap_q", 32'(bus.q), 32'hC);
        chk("gap_q_valid", 32'(bus.q_valid), 1);

        // stalled consumer: second word dropped
        idle(1);
        send_frame(1, 4'b1010, 0, 0);
        send_frame(1, 4'b0110, 0, 0);
        chk("ovr_q_held", 32'(bus.q), 32'hA);
        chk("ovr_flag", 32'(bus.overrun), 1);
        idle(1);
        chk("ovr_accept_q_valid", 32'(bus.q_valid), 0);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        step(0, 0, 0, 0, 1, 1);
        chk("ovr_cleared", 32'(bus.overrun), 0);

        // mid-frame abort, restart LSB-first
        step(1, 1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("abort_frame_err", 32'(bus.frame_err), 1);
        step(0, 0, 0, 1, 1, 0);
        chk("abort_frame_err_pulse", 32'(bus.frame_err), 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        chk("abort_q", 32'(bus.q), 32'h8);

        // async reset mid-frame, with a pending word and a set overrun flag
        send_frame(1, 4'b1111, 0, 0);
        send_frame(1, 4'b0001, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        #3 rst_n = 0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        send_frame(1, 4'b0101, 0, 1);
        chk("post_rst_q", 32'(bus.q), 32'h5);
        chk("post_rst_q_valid", 32'(bus.q_valid), 1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
